fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 89 ++++++++
 tb/tb_fetch_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch / sequencing unit: IDLE -> RUN -> HALTED control with
// program counter, branch handling, stall support and a saturating cycle counter.
module fetch_unit #(
  parameter int unsigned PW = 10,
  parameter int unsigned IW = 8,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [PW-1:0] start_addr,
  input  logic          stall,
  input  logic          branch_taken,
  output logic [PW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  output logic [IW-1:0] instruction,
  output logic [PW-1:0] pc,
  output logic          valid,
  output logic          done,
  output logic [CW-1:0] cycle_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [IW-1:0] HALT_OP = IW'(8'b0111_0000);

  state_t        state;
  logic          is_halt;
  logic          is_branch;
  logic [PW-1:0] branch_off;

  // Instruction path is purely combinational: zero latency from pc to decoder.
  always_comb begin
    imem_addr   = pc;
    instruction = imem_data;
    is_halt     = (imem_data == HALT_OP);
    is_branch   = (imem_data[7:6] == 2'b11);
    branch_off  = {{(PW-5){imem_data[4]}}, imem_data[4:0]};
  end

  // Sequencer: state, pc, counter and the registered valid/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      cycle_count <= '0;
      valid       <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            state       <= RUN;
            pc          <= start_addr;
            cycle_count <= '0;
            valid       <= 1'b1;
            done        <= 1'b0;
          end
        end
        RUN: begin
          if (!stall) begin
            if (cycle_count != '1) begin
              cycle_count <= cycle_count + 1'b1;
            end
            if (is_halt) begin
              state <= HALTED;
              valid <= 1'b0;
              done  <= 1'b1;
            end else if (is_branch && branch_taken) begin
              pc <= pc + branch_off;
            end else begin
              pc <= pc + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural model plus directed and random stimulus.
module tb_fetch_unit;

  localparam int PW   = 10;
  localparam int IW   = 8;
  localparam int CW   = 4;
  localparam int DEPTH = 1 << PW;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [PW-1:0] start_addr;
  logic          stall;
  logic          branch_taken;
  logic [PW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic [IW-1:0] instruction;
  logic [PW-1:0] pc;
  logic          valid;
  logic          done;
  logic [CW-1:0] cycle_count;

  logic [IW-1:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: running/halted flags, pc and counter as plain integers.
  bit m_run;
  bit m_halt;
  int m_pc;
  int m_cnt;

  fetch_unit #(.PW(PW), .IW(IW), .CW(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .start_addr   (start_addr),
    .stall        (stall),
    .branch_taken (branch_taken),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .instruction  (instruction),
    .pc           (pc),
    .valid        (valid),
    .done         (done),
    .cycle_count  (cycle_count)
  );

  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_halt = 1'b0;
    m_pc   = 0;
    m_cnt  = 0;
  endtask

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", int'(pc), m_pc);
      chk("imem_addr", int'(imem_addr), m_pc);
      chk("instruction", int'(instruction), int'(mem[m_pc]));
      chk("valid", int'(valid), int'(m_run));
      chk("done", int'(done), int'(m_halt));
      chk("cycle_count", int'(cycle_count), m_cnt);
    end
  end

  // One clock: compute the model's next state from current inputs, then advance.
  task automatic step();
    bit n_run, n_halt;
    int n_pc, n_cnt, off;
    logic [IW-1:0] ins;
    n_run = m_run; n_halt = m_halt; n_pc = m_pc; n_cnt = m_cnt;
    if (rst_n) begin
      if (!m_run) begin
        if (start) begin
          n_run = 1'b1; n_halt = 1'b0; n_pc = int'(start_addr); n_cnt = 0;
        end
      end else if (!stall) begin
        ins = mem[m_pc];
        n_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        if (ins == 8'h70) begin
          n_run = 1'b0; n_halt = 1'b1;
        end else if (ins[7:6] == 2'b11 && branch_taken) begin
          off  = int'(ins[4:0]);
          if (off >= 16) off = off - 32;
          n_pc = (m_pc + off + DEPTH) % DEPTH;
        end else begin
          n_pc = (m_pc + 1) % DEPTH;
        end
      end
    end
    @(posedge clk);
    m_run = n_run; m_halt = n_halt; m_pc = n_pc; m_cnt = n_cnt;
    #1;
  endtask

  // Abandon whatever is running with a short async reset, then start at addr.
  task automatic restart(input int addr);
    rst_n = 1'b0;
    model_reset();
    #1;
    rst_n = 1'b1;
    start = 1'b1;
    start_addr = PW'(addr);
    step();
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    rst_n = 1'b0; start = 1'b0; start_addr = '0; stall = 1'b0; branch_taken = 1'b0;
    model_reset();
    #1;
    chk("rst_pc", int'(pc), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cnt", int'(cycle_count), 0);
    chk_en = 1'b1;
    start = 1'b1;
    step(); step();
    chk("rst_hold_pc", int'(pc), 0);
    rst_n = 1'b1; start = 1'b0;
    step();
    chk("idle_valid", int'(valid), 0);

    // Straight-line run of NOPs from 0x010, counter saturates at 15
    start = 1'b1; start_addr = 10'h010;
    step();
    start = 1'b0;
    chk("seq_pc0", int'(pc), 'h010);
    chk("seq_cnt0", int'(cycle_count), 0);
    chk("seq_valid", int'(valid), 1);
    step();
    chk("seq_pc1", int'(pc), 'h011);
    chk("seq_cnt1", int'(cycle_count), 1);
    step();
    chk("seq_pc2", int'(pc), 'h012);
    for (int i = 0; i < 20; i++) step();
    chk("cnt_sat", int'(cycle_count), 15);
    chk("model_cnt_sat", m_cnt, 15);

    // BLT offset -3 at 0x020, taken and not taken
    mem[10'h020] = 8'b1101_1101;
    restart('h020); branch_taken = 1'b1; step();
    chk("blt_taken", int'(pc), 'h01D);
    chk("model_blt_taken", m_pc, 'h01D);
    restart('h020); branch_taken = 1'b0; step();
    chk("blt_not_taken", int'(pc), 'h021);

    // Wrap forward and backward
    mem[10'h3FF] = 8'h00;
    restart('h3FF); step();
    chk("wrap_fwd", int'(pc), 'h000);
    mem[10'h001] = 8'b1111_1100;
    restart('h001); branch_taken = 1'b1; step();
    chk("wrap_back", int'(pc), 'h3FD);
    chk("model_wrap_back", m_pc, 'h3FD);

    // Self-loop with offset 0
    mem[10'h050] = 8'b1100_0000;
    restart('h050); step(); step();
    chk("self_loop_pc", int'(pc), 'h050);
    chk("self_loop_cnt", int'(cycle_count), 2);
    branch_taken = 1'b0;

    // HALT ignores branch_taken; restart from HALTED
    mem[10'h005] = 8'h70;
    restart('h005); branch_taken = 1'b1; step();
    chk("halt_pc", int'(pc), 'h005);
    chk("halt_done", int'(done), 1);
    chk("halt_valid", int'(valid), 0);
    chk("halt_cnt", int'(cycle_count), 1);
    stall = 1'b1; step(); step(); stall = 1'b0;
    chk("halted_hold_pc", int'(pc), 'h005);
    start = 1'b1; start_addr = 10'h040; step(); start = 1'b0;
    chk("restart_pc", int'(pc), 'h040);
    chk("restart_cnt", int'(cycle_count), 0);
    chk("restart_done", int'(done), 0);
    branch_taken = 1'b0;

    // Stall three cycles on a taken BLT +5 at 0x030
    mem[10'h030] = 8'b1100_0101;
    restart('h030); branch_taken = 1'b1; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", int'(pc), 'h030);
      chk("stall_cnt", int'(cycle_count), 0);
      chk("stall_valid", int'(valid), 1);
    end
    stall = 1'b0; step();
    chk("stall_release_pc", int'(pc), 'h035);
    chk("stall_release_cnt", int'(cycle_count), 1);
    branch_taken = 1'b0;

    // start ignored mid-program, then async reset between edges at 0x123
    for (int i = 0; i < 8; i++) mem[10'h120 + i] = 8'h00;
    restart('h11F); step();
    start = 1'b1; start_addr = 10'h200; step(); start = 1'b0;
    chk("start_ignored", int'(pc), 'h121);
    step(); step();
    chk("pre_reset_pc", int'(pc), 'h123);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", int'(pc), 0);
    chk("async_rst_valid", int'(valid), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    chk("post_reset_idle", int'(valid), 0);

    // Randomized program and control inputs
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = IW'($urandom);
      if ($urandom_range(0, 31) == 0) mem[i] = 8'h70;
    end
    for (int c = 0; c < 3000; c++) begin
      start        = ($urandom_range(0, 7) == 0);
      start_addr   = PW'($urandom);
      stall        = ($urandom_range(0, 3) == 0);
      branch_taken = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
      end
      step();
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
